mesi_cache_sequencer: RTL
=========================

MESI_CACHE_SEQUENCER -- requirements
Module: mesi_cache_sequencer

Interface
REQ-001 The parameter list SHALL be: ADDR_W, default 32, address width.
REQ-002 The parameter list SHALL also include: SNOOP_TMO, default 15, maximum number of SNOOP cycles to wait for bus_snoop_done (valid range 1..255).
REQ-003 Ports SHALL be as follows; outputs marked "(ptn)" are the state-FSM operands.
  clk  in  1  single clock; all state changes on its rising edge.
  rst  in  1  asynchronous, active-high reset.
  cpu_valid  in  1  CPU request present.
  cpu_req  in  2  00 NOP, 01 RD, 10 WR; 11 reserved.
  cpu_addr  in  ADDR_W  request line address.
  cpu_ready  out  1  sequencer can accept a request.
  cpu_done  out  1  one-cycle completion pulse.
  cpu_err  out  1  qualifies cpu_done: snoop timeout.
  tag_rd_en  out  1  tag-array state read strobe.
  tag_addr  out  ADDR_W  latched request address.
  tag_state_i  in  2  line state (I=00, S=01, E=10, M=11), valid the cycle after tag_rd_en.
  tag_wr_en  out  1  tag-array state write strobe.
  tag_wr_state  out  2  state to write.
  fsm_cur_state  out  2  (ptn) current line state.
  fsm_cpu_req  out  2  (ptn) request.
  fsm_bus_shared  out  1  (ptn) shared indication.
  fsm_next_state  in  2  state-FSM result.
  fsm_bus_req_type  in  2  state-FSM bus request (00 NOP, 01 RD, 10 WR).
  bus_req  out  1  bus arbitration request.
  bus_gnt  in  1  bus grant.
  bus_valid  out  1  bus command valid.
  bus_cmd  out  2  bus command (01 RD, 10 WR).
  bus_addr  out  ADDR_W  bus address.
  bus_snoop_done  in  1  all peers have snooped.
  bus_shared  in  1  a peer holds the line; sampled with bus_snoop_done.

Function
REQ-004 The FSM SHALL have states IDLE, LOOKUP, DECIDE, ARB, SNOOP and COMMIT; only one request is in flight at a time.
REQ-005 cpu_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE with cpu_valid=1 and cpu_req in {01,10}: latch cpu_req and cpu_addr, pulse tag_rd_en for that cycle, go to LOOKUP; cpu_req 00 or 11 SHALL be ignored (stay IDLE, no done).
REQ-007 LOOKUP SHALL register tag_state_i into cur_state and go to DECIDE (1 cycle).
REQ-008 From DECIDE through SNOOP, fsm_cur_state and fsm_cpu_req SHALL carry the latched cur_state and request; fsm_bus_shared SHALL be 0 except as stated in REQ-012; in IDLE, LOOKUP and COMMIT all three outputs SHALL be 0.
REQ-009 In DECIDE, if fsm_bus_req_type=00: latch fsm_next_state and go to COMMIT; otherwise latch fsm_bus_req_type as bus_cmd and go to ARB.
REQ-010 ARB SHALL hold bus_req=1 until bus_gnt is sampled 1, then go to SNOOP; bus_req SHALL be 0 in every other state.
REQ-011 In SNOOP, bus_valid SHALL be 1 with bus_cmd and bus_addr (= latched address) stable; bus_valid, bus_cmd and bus_addr SHALL be 0 elsewhere.
REQ-012 In a SNOOP cycle with bus_snoop_done=1: drive fsm_bus_shared=bus_shared in the same cycle, latch fsm_next_state and go to COMMIT.
REQ-013 A cycle counter SHALL count SNOOP cycles from 1; if bus_snoop_done is still 0 in cycle SNOOP_TMO, the request SHALL abort: go to IDLE, pulse cpu_done=1 with cpu_err=1 in that cycle, and perform no tag write.
REQ-014 COMMIT SHALL pulse tag_wr_en=1 with tag_wr_state = latched next state for exactly one cycle, pulse cpu_done=1 (cpu_err=0), and return to IDLE.
REQ-015 Latency from the accept cycle T SHALL be as follows. For a no-bus request, done occurs at T+3. For a bus request, with grant sampled in cycle G and snoop_done in cycle D, done occurs at D+1, where D is at least G+1.
REQ-016 A new request SHALL be accepted no earlier than the cycle after cpu_done.
REQ-017 bus_gnt SHALL be ignored outside ARB, and bus_snoop_done SHALL be ignored outside SNOOP.

Reset
REQ-018 Asserting rst at any time SHALL immediately force IDLE and clear all latched fields and the counter.
REQ-019 While rst is asserted, every output SHALL be 0, except cpu_ready, which SHALL be 1 after the first clock edge with rst low and is 0 during reset.
REQ-020 Reset mid-transaction SHALL drop the request without a tag write or cpu_done.

Verification
REQ-021 RD with tag=I, bus_shared=1: the sequencer SHALL issue bus RD, then tag_wr_state=S and cpu_done with no error.
REQ-022 RD with tag=I, bus_shared=0: the sequencer SHALL write E.
REQ-023 WR with tag=E: there SHALL be no bus activity; tag write M and cpu_done SHALL occur exactly 3 cycles after accept.
REQ-024 WR with tag=S, bus_gnt delayed 4 cycles: bus_req SHALL be held for 4 cycles, then bus_cmd=10, then M is written.
REQ-025 Bus RD where bus_snoop_done never arrives: after 15 SNOOP cycles, the sequencer SHALL assert cpu_done=1 and cpu_err=1, with no tag_wr_en and no tag write.
REQ-026 rst pulsed during SNOOP: outputs SHALL go to 0 at once and there SHALL be no cpu_done; the next RD SHALL be processed normally.
REQ-027 cpu_req=11 and cpu_req=00 with cpu_valid=1: the sequencer SHALL ignore them, with cpu_ready staying 1 and no tag_rd_en.

Source files
------------

// File: rtl/mesi_cache_sequencer.sv
// MESI cache request sequencer: tag lookup, external state-FSM decision,
// bus arbitration/snoop with timeout, and tag write-back of the new line state.
//
// state  | meaning
// IDLE   | ready for a CPU request
// LOOKUP | tag state read returns, captured into cur_state
// DECIDE | state FSM picks next state or a bus command
// ARB    | requesting the bus until granted
// SNOOP  | bus command issued, waiting for peers (bounded)
// COMMIT | write new line state, signal completion
module mesi_cache_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int SNOOP_TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic [1:0]        cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              tag_rd_en,
    output logic [ADDR_W-1:0] tag_addr,
    input  logic [1:0]        tag_state_i,
    output logic              tag_wr_en,
    output logic [1:0]        tag_wr_state,
    output logic [1:0]        fsm_cur_state,
    output logic [1:0]        fsm_cpu_req,
    output logic              fsm_bus_shared,
    input  logic [1:0]        fsm_next_state,
    input  logic [1:0]        fsm_bus_req_type,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_valid,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_snoop_done,
    input  logic              bus_shared
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_DECIDE, S_ARB, S_SNOOP, S_COMMIT
    } state_t;

    // Down-counter loaded on grant; reaching zero marks the last allowed SNOOP cycle.
    localparam logic [7:0] TMO_LOAD = 8'(SNOOP_TMO - 1);

    state_t            state, state_nxt;
    logic              rdy_q;
    logic [1:0]        req_q, cur_q, nxt_q, cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        cnt_q;
    logic              accept;

    // rdy_q keeps cpu_ready low until the first clock edge after reset release.
    assign accept   = (state == S_IDLE) && rdy_q && cpu_valid &&
                      ((cpu_req == 2'b01) || (cpu_req == 2'b10));
    assign tag_addr = accept ? cpu_addr : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            rdy_q  <= 1'b0;
            req_q  <= '0;
            cur_q  <= '0;
            nxt_q  <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_q  <= cpu_req;
                        addr_q <= cpu_addr;
                    end
                end
                S_LOOKUP: cur_q <= tag_state_i;
                S_DECIDE: begin
                    if (fsm_bus_req_type == 2'b00) nxt_q <= fsm_next_state;
                    else                           cmd_q <= fsm_bus_req_type;
                end
                S_ARB: begin
                    if (bus_gnt) cnt_q <= TMO_LOAD;
                end
                S_SNOOP: begin
                    if (bus_snoop_done)     nxt_q <= fsm_next_state;
                    else if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu_ready      = 1'b0;
        cpu_done       = 1'b0;
        cpu_err        = 1'b0;
        tag_rd_en      = 1'b0;
        tag_wr_en      = 1'b0;
        tag_wr_state   = 2'b00;
        fsm_cur_state  = 2'b00;
        fsm_cpu_req    = 2'b00;
        fsm_bus_shared = 1'b0;
        bus_req        = 1'b0;
        bus_valid      = 1'b0;
        bus_cmd        = 2'b00;
        bus_addr       = '0;
        case (state)
            S_IDLE: begin
                cpu_ready = rdy_q;
                tag_rd_en = accept;
                if (accept) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: state_nxt = S_DECIDE;
            S_DECIDE: begin
                fsm_cur_state = cur_q;
                fsm_cpu_req   = req_q;
                state_nxt     = (fsm_bus_req_type == 2'b00) ? S_COMMIT : S_ARB;
            end
            S_ARB: begin
                fsm_cur_state = cur_q;
                fsm_cpu_req   = req_q;
                bus_req       = 1'b1;
                if (bus_gnt) state_nxt = S_SNOOP;
            end
            S_SNOOP: begin
                fsm_cur_state = cur_q;
                fsm_cpu_req   = req_q;
                bus_valid     = 1'b1;
                bus_cmd       = cmd_q;
                bus_addr      = addr_q;
                if (bus_snoop_done) begin
                    fsm_bus_shared = bus_shared;
                    state_nxt      = S_COMMIT;
                end else if (cnt_q == 8'd0) begin
                    cpu_done  = 1'b1;
                    cpu_err   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                tag_wr_en    = 1'b1;
                tag_wr_state = nxt_q;
                cpu_done     = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
